pc_gen: RTL and testbench

Parametrised fetch-PC generator for the superscalar front end. It is the successor to the single-lane PC controller. It issues aligned fetch-group addresses with a valid/ready request handshake and waits for the burst-completion beat (`rlast`). It arbitrates redirects from decode (JAL) and execute (JALR/conditional branch), and holds a redirect that arrives mid-burst until that burst completes. It maintains a fetch epoch so downstream stages can discard wrong-path groups.

---
 rtl/pc_gen_pkg.sv | 41 ++++
 rtl/pc_redirect_arb.sv | 37 +++
 rtl/pc_gen.sv | 140 ++++++++++++++
 tb/tb_pc_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and address helpers for the fetch-PC generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DEC  = 2'd1,
        EX   = 2'd2
    } src_e;

    // Widest address and group the helpers handle; callers truncate the results.
    localparam int unsigned MAX_XLEN = 64;
    localparam int unsigned MAX_FW   = 8;

    // Clear the byte-offset-in-group bits (log2(fw)+2 low bits).
    function automatic logic [MAX_XLEN-1:0] group_align(input logic [MAX_XLEN-1:0] addr,
                                                        input int unsigned         fw);
        logic [MAX_XLEN-1:0] grp_bytes;
        grp_bytes = MAX_XLEN'(fw) << 2;
        return addr & ~(grp_bytes - MAX_XLEN'(1));
    endfunction

    // Lane i is live when it sits at or after the PC's word slot in the group.
    function automatic logic [MAX_FW-1:0] lane_mask(input logic [MAX_XLEN-1:0] addr,
                                                    input int unsigned         fw);
        logic [MAX_XLEN-1:0] word_off;
        logic [MAX_FW-1:0]   mask;
        word_off = (addr >> 2) & (MAX_XLEN'(fw) - MAX_XLEN'(1));
        mask     = '0;
        for (int unsigned i = 0; i < MAX_FW; i++) begin
            mask[i] = (i < fw) && (MAX_XLEN'(i) >= word_off);
        end
        return mask;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: execute beats decode; a misaligned winner is flagged
// instead of winning, and the loser is dropped regardless.
import pc_gen_pkg::*;

module pc_redirect_arb #(
    parameter int unsigned XLEN = 32
) (
    input  logic            dec_redirect_i,
    input  logic [XLEN-1:0] dec_target_i,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic            win_o,
    output logic [XLEN-1:0] target_o,
    output src_e            src_o,
    output logic            err_o
);

    logic any_req;
    logic misaligned;

    // Priority select, then qualify the winner by word alignment.
    always_comb begin
        target_o = dec_target_i;
        src_o    = NONE;
        if (ex_redirect_i) begin
            target_o = ex_target_i;
            src_o    = EX;
        end else if (dec_redirect_i) begin
            src_o    = DEC;
        end
        any_req    = ex_redirect_i | dec_redirect_i;
        misaligned = (target_o[1:0] != 2'b00);
        win_o      = any_req & ~misaligned;
        err_o      = any_req & misaligned;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: issues group-aligned fetch requests, waits for the
// burst's last beat, and folds decode/execute redirects in, deferring any
// that land while a request is outstanding.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | request presented, address/mask held until accepted
// WAIT  | request accepted, waiting for rlast
import pc_gen_pkg::*;

module pc_gen #(
    parameter int unsigned            XLEN        = 32,
    parameter int unsigned            FETCH_WIDTH = 2,
    parameter logic [XLEN-1:0]        RESET_PC    = '0,
    parameter int unsigned            EPOCH_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_redirect,
    input  logic [XLEN-1:0]        dec_target,
    input  logic                   ex_redirect,
    input  logic [XLEN-1:0]        ex_target,
    output logic                   fetch_req_valid,
    input  logic                   fetch_req_ready,
    output logic [XLEN-1:0]        fetch_addr,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    input  logic                   rlast,
    output logic [EPOCH_W-1:0]     fetch_epoch,
    output logic                   misalign_err
);

    localparam logic [XLEN-1:0] GROUP_BYTES = XLEN'(FETCH_WIDTH * 4);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    pend_tgt_q, pend_tgt_d;
    src_e               pend_src_q, pend_src_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               err_q, err_d;

    logic               arb_win;
    logic [XLEN-1:0]    arb_tgt;
    src_e               arb_src;
    logic               arb_err;
    logic               defer_slot;
    logic [XLEN-1:0]    seq_addr;

    pc_redirect_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .dec_redirect_i (dec_redirect),
        .dec_target_i   (dec_target),
        .ex_redirect_i  (ex_redirect),
        .ex_target_i    (ex_target),
        .win_o          (arb_win),
        .target_o       (arb_tgt),
        .src_o          (arb_src),
        .err_o          (arb_err)
    );

    assign fetch_addr      = XLEN'(group_align(MAX_XLEN'(pc_q), FETCH_WIDTH));
    assign fetch_mask      = FETCH_WIDTH'(lane_mask(MAX_XLEN'(pc_q), FETCH_WIDTH));
    assign fetch_req_valid = (state_q == REQ);
    assign fetch_epoch     = epoch_q;
    assign misalign_err    = err_q;
    assign seq_addr        = fetch_addr + GROUP_BYTES;

    // The address cannot move while a request is presented or in flight.
    assign defer_slot = (state_q == REQ) || ((state_q == WAIT) && !rlast);

    // Next state, next PC, pending redirect and epoch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_src_d = pend_src_q;
        epoch_d    = epoch_q;
        err_d      = arb_err;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (arb_win) begin
                    pc_d    = arb_tgt;
                    epoch_d = epoch_q + EPOCH_W'(1);
                end
            end
            REQ: begin
                if (fetch_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rlast) begin
                    state_d    = REQ;
                    pend_src_d = NONE;
                    if (arb_win) begin
                        pc_d    = arb_tgt;
                        epoch_d = epoch_q + EPOCH_W'(1);
                    end else if (pend_src_q != NONE) begin
                        pc_d = pend_tgt_q;
                    end else begin
                        pc_d = seq_addr;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                pend_src_d = NONE;
            end
        endcase

        // A decode redirect behind a pending execute one is on the wrong path.
        if (defer_slot && arb_win && ((arb_src == EX) || (pend_src_q != EX))) begin
            pend_tgt_d = arb_tgt;
            pend_src_d = arb_src;
            epoch_d    = epoch_q + EPOCH_W'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pend_src_q <= NONE;
            epoch_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_src_q <= pend_src_d;
            epoch_q    <= epoch_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen (XLEN=32, FETCH_WIDTH=2, RESET_PC=0, EPOCH_W=2).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_redirect = 1'b0;
    logic [31:0] dec_target = '0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        fetch_req_valid;
    logic        fetch_req_ready = 1'b0;
    logic [31:0] fetch_addr;
    logic [1:0]  fetch_mask;
    logic        rlast = 1'b0;
    logic [1:0]  fetch_epoch;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  mask;
        logic [1:0]  epoch;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pc_gen #(
        .XLEN        (32),
        .FETCH_WIDTH (2),
        .RESET_PC    (32'h0),
        .EPOCH_W     (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dec_redirect    (dec_redirect),
        .dec_target      (dec_target),
        .ex_redirect     (ex_redirect),
        .ex_target       (ex_target),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_mask      (fetch_mask),
        .rlast           (rlast),
        .fetch_epoch     (fetch_epoch),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: every accepted request is compared against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && fetch_req_valid && fetch_req_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_req: got addr 0x%0h with no expectation queued", fetch_addr);
            end else begin
                e = exp_q.pop_front();
                chk("req_addr",  fetch_addr,          e.addr);
                chk("req_mask",  32'(fetch_mask),     32'(e.mask));
                chk("req_epoch", 32'(fetch_epoch),    32'(e.epoch));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [31:0] a, input logic [1:0] m, input logic [1:0] ep);
        exp_t e;
        e.addr  = a;
        e.mask  = m;
        e.epoch = ep;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a request, then accept it for one cycle.
    task automatic accept();
        int n;
        n = 0;
        while (!fetch_req_valid && n < 10) begin
            step();
            n++;
        end
        if (!fetch_req_valid) begin
            n_checks++;
            $display("FAIL req_timeout: got valid=0 expected valid=1 within 10 cycles");
        end else begin
            fetch_req_ready = 1'b1;
            step();
            fetch_req_ready = 1'b0;
        end
    endtask

    task automatic burst_end();
        rlast = 1'b1;
        step();
        rlast = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and sequential fetch.
        step();
        step();
        step();
        chk("rst_valid", 32'(fetch_req_valid), 32'd0);
        chk("rst_addr",  fetch_addr,           32'h0);
        chk("rst_mask",  32'(fetch_mask),      32'h3);
        chk("rst_epoch", 32'(fetch_epoch),     32'd0);
        chk("rst_err",   32'(misalign_err),    32'd0);
        rst = 1'b0;
        chk("idle_valid", 32'(fetch_req_valid), 32'd0);
        step();
        chk("first_valid", 32'(fetch_req_valid), 32'd1);
        expect_req(32'h0, 2'b11, 2'd0);
        accept();
        burst_end();
        expect_req(32'h8, 2'b11, 2'd0);
        accept();
        burst_end();
        expect_req(32'h10, 2'b11, 2'd0);
        accept();
        burst_end();

        // Redirect in IDLE to mid-group target.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        dec_redirect = 1'b1;
        dec_target   = 32'h104;
        step();
        dec_redirect = 1'b0;
        chk("idle_redir_epoch", 32'(fetch_epoch), 32'd1);
        expect_req(32'h100, 2'b10, 2'd1);
        accept();

        // Mid-burst redirects: dec, ex overwrite, dec ignored behind ex.
        do_reset();
        step();
        expect_req(32'h0, 2'b11, 2'd0);
        accept();
        dec_redirect = 1'b1; dec_target = 32'h40;
        step();
        dec_redirect = 1'b0; ex_redirect = 1'b1; ex_target = 32'h80;
        step();
        ex_redirect = 1'b0; dec_redirect = 1'b1; dec_target = 32'h60;
        step();
        dec_redirect = 1'b0;
        chk("pend_epoch", 32'(fetch_epoch), 32'd2);
        chk("pend_addr_held", fetch_addr, 32'h0);
        burst_end();
        expect_req(32'h80, 2'b11, 2'd2);
        accept();

        // Simultaneous dec/ex on the rlast cycle: ex wins, epoch +1 only.
        dec_redirect = 1'b1; dec_target = 32'h20;
        ex_redirect  = 1'b1; ex_target  = 32'h30;
        rlast = 1'b1;
        step();
        rlast = 1'b0; dec_redirect = 1'b0; ex_redirect = 1'b0;
        expect_req(32'h30, 2'b11, 2'd3);
        accept();

        // Misaligned ex target mid-burst: one-cycle pulse, nothing else moves.
        ex_redirect = 1'b1; ex_target = 32'h102;
        step();
        ex_redirect = 1'b0;
        chk("mis_err_hi",  32'(misalign_err), 32'd1);
        chk("mis_epoch",   32'(fetch_epoch),  32'd3);
        step();
        chk("mis_err_lo",  32'(misalign_err), 32'd0);
        burst_end();
        expect_req(32'h38, 2'b11, 2'd3);
        accept();

        // Misaligned ex on rlast also drops an aligned dec; sequential follows.
        ex_redirect = 1'b1; ex_target = 32'h103;
        dec_redirect = 1'b1; dec_target = 32'h200;
        rlast = 1'b1;
        step();
        rlast = 1'b0; ex_redirect = 1'b0; dec_redirect = 1'b0;
        chk("mis2_err", 32'(misalign_err), 32'd1);
        expect_req(32'h40, 2'b11, 2'd3);
        accept();

        // Top-of-space group wraps to 0; epoch wraps 3 -> 0.
        ex_redirect = 1'b1; ex_target = 32'hFFFF_FFF8;
        rlast = 1'b1;
        step();
        rlast = 1'b0; ex_redirect = 1'b0;
        expect_req(32'hFFFF_FFF8, 2'b11, 2'd0);
        accept();
        burst_end();
        rlast = 1'b1;
        step();
        rlast = 1'b0;
        chk("rlast_in_req_valid", 32'(fetch_req_valid), 32'd1);
        chk("rlast_in_req_addr",  fetch_addr,           32'h0);
        expect_req(32'h0, 2'b11, 2'd0);
        accept();

        // Reset in WAIT with a pending redirect and a late rlast.
        ex_redirect = 1'b1; ex_target = 32'h500;
        step();
        ex_redirect = 1'b0;
        chk("pend2_epoch", 32'(fetch_epoch), 32'd1);
        rst = 1'b1; rlast = 1'b1;
        step();
        rst = 1'b0; rlast = 1'b0;
        chk("rst2_valid", 32'(fetch_req_valid), 32'd0);
        chk("rst2_epoch", 32'(fetch_epoch),     32'd0);
        chk("rst2_addr",  fetch_addr,           32'h0);
        step();
        expect_req(32'h0, 2'b11, 2'd0);
        accept();
        burst_end();

        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
